burst_write_scheduler: RTL and testbench
========================================

# burst_write_scheduler

Round-robin scheduler that shares the single write port of a burst FIFO between NREQ requesters, all in the wr_clk domain. It grants one requester a fixed BURST_LEN-word burst at a time, tags each burst with its channel number for the downstream TDM datapath, and pads stalled bursts with zeros after a timeout. It never overruns the FIFO, because it tracks free space with a credit counter that the read side replenishes.

## Interface
- NREQ, 4, number of requesters (2..16)
- WIDTH, 8, data word width
- BURST_LEN, 16, words per burst (2..DEPTH)
- DEPTH, 100, FIFO capacity in words; initial credit count
- TIMEOUT, 8, consecutive idle cycles inside a burst before padding starts (>=1)
- CHW, $clog2(NREQ), channel-id width
- wr_clk  in  1  clock; all logic is on its rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NREQ  per-requester word valid
- req_data  in  NREQ*WIDTH  per-requester word; channel i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- rd_free  in  1  one FIFO word consumed by the read side; already in the wr_clk domain
- fifo_wr_en  out  1  FIFO write strobe
- fifo_din  out  WIDTH  FIFO write data
- fifo_ch  out  CHW  channel id of the current word
- burst_start  out  1  high with the first word of a burst
- burst_end  out  1  high with the last word of a burst
- burst_padded  out  1  high with burst_end when any word of the burst was padding
- credit_err  out  1  sticky flag: rd_free arrived while credits == DEPTH

## Operation
- The FSM has three states: IDLE, BURST and PAD. Reset enters IDLE.
- IDLE:
  - Eligible requesters are those with req_valid high.
  - If at least one is eligible and credits >= BURST_LEN, grant the first eligible channel searching from rr_ptr+1 modulo NREQ.
  - On grant: register the channel in g, subtract BURST_LEN from credits, clear the word counter and the idle counter, and go to BURST.
  - With no eligible requester or too few credits, stay in IDLE. No partial bursts are ever granted.
- BURST:
  - req_ready[g] = 1; all other ready bits are 0.
  - A word is accepted when req_valid[g] && req_ready[g]. Each accepted word increments the word counter and clears the idle counter.
  - A cycle without an accepted word increments the idle counter.
  - When the word counter reaches BURST_LEN (last word accepted), set rr_ptr = g and go to IDLE.
  - When the idle counter reaches TIMEOUT, go to PAD.
- PAD:
  - req_ready is all zero.
  - Write one zero word per cycle until BURST_LEN words are written in total.
  - Then set rr_ptr = g and go to IDLE.
- req_ready is decoded combinationally from the registered state and g only; it never depends on req_valid.
- Credit accounting happens every cycle:
  - credits_next = credits - (grant ? BURST_LEN : 0) + (rd_free ? 1 : 0).
  - Simultaneous grant and rd_free apply both.
  - An rd_free arriving at credits == DEPTH with no grant in that cycle is dropped and sets credit_err.
  - Credits are never negative: the grant condition guarantees this.
- credit_err clears only on rst.

## Timing
- Reset values:
  - All outputs are 0.
  - credits = DEPTH, g = 0, rr_ptr = NREQ-1, so channel 0 has first priority.
  - Counters are 0.
- Grant latency: req_valid seen in IDLE means req_ready is high on the next cycle. One IDLE cycle separates consecutive bursts.
- Write-port latency:
  - fifo_wr_en, fifo_din, fifo_ch, burst_start, burst_end and burst_padded are registered.
  - A word accepted (or padded) in cycle k appears on them in cycle k+1.
- burst_start marks the first word of a burst, whether that word is accepted or padded.
- burst_end marks word BURST_LEN; burst_padded is valid only in that same cycle.
- Exactly BURST_LEN fifo_wr_en pulses occur per grant.
- rst mid-burst:
  - Abandons the burst at once; no burst_end is produced.
  - Writes already issued are not undone.
  - Credits return to DEPTH. The FIFO is expected to be reset by the same rst.

## Test plan
- NREQ=4, BURST_LEN=16, DEPTH=100, all four requesters valid continuously with data = channel*16 + index:
  - Bursts are granted in order 0,1,2,3.
  - Each burst gives 16 consecutive fifo_wr_en pulses with the matching fifo_ch.
  - burst_start fires on the first word and burst_end on the sixteenth.
  - There is one idle cycle between bursts.
- No rd_free from reset:
  - Six bursts are granted (credits 100 -> 4).
  - The seventh is withheld and req_ready stays 0.
  - 12 rd_free pulses bring credits to 16, and the next grant follows one cycle later.
- Channel 2 drops req_valid after 5 words, TIMEOUT=8:
  - After 8 idle cycles, 11 zero words are written.
  - burst_end and burst_padded are high together.
  - The next grant goes to channel 3.
- Only channel 1 valid, then channel 0 asserts mid-burst:
  - Channel 1's burst completes untouched.
  - Channel 0 is granted next.
  - The burst after that goes to channel 1 again if both stay valid.
- Grant cycle coincident with rd_free at credits = 16: credits become 1 on the next cycle.
- rd_free pulsed at credits = 100 with no grant:
  - credit_err rises and stays high.
  - Credits remain 100.
- rst asserted at word 7 of a burst:
  - On the next cycle all outputs are 0 and credits = 100.
  - Channel 0 has first priority again.

Source files
------------

// File: rtl/burst_write_scheduler.sv
// Round-robin burst scheduler for a shared FIFO write port. Grants fixed-length
// bursts, tags words with the channel id, zero-pads stalled bursts, tracks FIFO credits.
module burst_write_scheduler #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 16,
  parameter int DEPTH     = 100,
  parameter int TIMEOUT   = 8,
  parameter int CHW       = $clog2(NREQ)
) (
  input  logic                    wr_clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    rd_free,
  output logic                    fifo_wr_en,
  output logic [WIDTH-1:0]        fifo_din,
  output logic [CHW-1:0]          fifo_ch,
  output logic                    burst_start,
  output logic                    burst_end,
  output logic                    burst_padded,
  output logic                    credit_err
);

  localparam int CRW = $clog2(DEPTH + 1);
  localparam int WCW = $clog2(BURST_LEN + 1);
  localparam int ICW = $clog2(TIMEOUT + 1);
  localparam logic [CRW-1:0] CR_MAX   = CRW'(DEPTH);
  localparam logic [CRW-1:0] CR_BURST = CRW'(BURST_LEN);
  localparam logic [WCW-1:0] W_LAST   = WCW'(BURST_LEN - 1);
  localparam logic [ICW-1:0] I_LAST   = ICW'(TIMEOUT - 1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(NREQ - 1);
  localparam logic [CHW:0]   N_WRAP   = (CHW+1)'(NREQ);

  typedef enum logic [1:0] {IDLE, BURST, PAD} state_t;

  state_t                     state;
  logic [CHW-1:0]             g, rr_ptr, pick;
  logic [CHW:0]               sidx;
  logic                       found, grant, accept;
  logic [WCW-1:0]             wcnt;
  logic [ICW-1:0]             icnt;
  logic [CRW-1:0]             credits;
  logic [NREQ-1:0][WIDTH-1:0] data_arr;

  assign data_arr = req_data;

  // Ready depends only on registered state, never on req_valid.
  for (genvar i = 0; i < NREQ; i++) begin : g_rdy
    assign req_ready[i] = (state == BURST) && (g == CHW'(i));
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    sidx  = '0;
    for (int off = 1; off <= NREQ; off++) begin
      sidx = {1'b0, rr_ptr} + (CHW+1)'(off);
      if (sidx >= N_WRAP) sidx = sidx - N_WRAP;
      if (!found && req_valid[sidx[CHW-1:0]]) begin
        found = 1'b1;
        pick  = sidx[CHW-1:0];
      end
    end
  end

  assign grant  = (state == IDLE) && found && (credits >= CR_BURST);
  assign accept = (state == BURST) && req_valid[g];

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state        <= IDLE;
      g            <= '0;
      rr_ptr       <= CH_LAST;
      wcnt         <= '0;
      icnt         <= '0;
      credits      <= CR_MAX;
      credit_err   <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_din     <= '0;
      fifo_ch      <= '0;
      burst_start  <= 1'b0;
      burst_end    <= 1'b0;
      burst_padded <= 1'b0;
    end else begin
      fifo_wr_en   <= 1'b0;
      fifo_din     <= '0;
      fifo_ch      <= '0;
      burst_start  <= 1'b0;
      burst_end    <= 1'b0;
      burst_padded <= 1'b0;

      // A return with no grant while already full is a read-side bookkeeping error.
      if (grant)
        credits <= credits - CR_BURST + CRW'(rd_free);
      else if (rd_free && credits == CR_MAX)
        credit_err <= 1'b1;
      else if (rd_free)
        credits <= credits + CRW'(1);

      case (state)
        IDLE: begin
          if (grant) begin
            g     <= pick;
            wcnt  <= '0;
            icnt  <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            fifo_wr_en  <= 1'b1;
            fifo_din    <= data_arr[g];
            fifo_ch     <= g;
            burst_start <= (wcnt == '0);
            burst_end   <= (wcnt == W_LAST);
            wcnt        <= wcnt + WCW'(1);
            icnt        <= '0;
            if (wcnt == W_LAST) begin
              rr_ptr <= g;
              state  <= IDLE;
            end
          end else begin
            icnt <= icnt + ICW'(1);
            if (icnt == I_LAST) state <= PAD;
          end
        end
        PAD: begin
          fifo_wr_en   <= 1'b1;
          fifo_ch      <= g;
          burst_start  <= (wcnt == '0);
          burst_end    <= (wcnt == W_LAST);
          burst_padded <= (wcnt == W_LAST);
          wcnt         <= wcnt + WCW'(1);
          if (wcnt == W_LAST) begin
            rr_ptr <= g;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_write_scheduler.sv
// Directed bench for burst_write_scheduler: round-robin order, credits, padding,
// credit_err and mid-burst reset, all against hand-computed values.
module tb_burst_write_scheduler;
  localparam int NREQ = 4, WIDTH = 8, BL = 16, DEPTH = 100, TO = 8, CHW = 2;

  logic                  wr_clk = 1'b0;
  logic                  rst, rd_free;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  fifo_wr_en, burst_start, burst_end, burst_padded, credit_err;
  logic [WIDTH-1:0]      fifo_din;
  logic [CHW-1:0]        fifo_ch;

  int n_run = 0, n_fail = 0, cyc = 0;
  int widx [NREQ];

  typedef struct {int cyc; int ch; int din; bit s; bit e; bit p;} wr_t;
  wr_t wq[$];

  burst_write_scheduler #(
    .NREQ(NREQ), .WIDTH(WIDTH), .BURST_LEN(BL), .DEPTH(DEPTH), .TIMEOUT(TO), .CHW(CHW)
  ) dut (
    .wr_clk(wr_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rd_free(rd_free), .fifo_wr_en(fifo_wr_en),
    .fifo_din(fifo_din), .fifo_ch(fifo_ch), .burst_start(burst_start),
    .burst_end(burst_end), .burst_padded(burst_padded), .credit_err(credit_err)
  );

  always #5 wr_clk = ~wr_clk;

  always @(negedge wr_clk) begin
    cyc++;
    if (fifo_wr_en === 1'b1)
      wq.push_back('{cyc, int'(fifo_ch), int'(fifo_din), burst_start, burst_end, burst_padded});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_data();
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'(i*16 + widx[i]);
  endtask

  task automatic clr_data();
    for (int i = 0; i < NREQ; i++) widx[i] = 0;
    set_data();
  endtask

  // Advance one cycle; a channel whose word was accepted presents its next word.
  task automatic step();
    logic [NREQ-1:0] acc;
    acc = req_valid & req_ready & {NREQ{~rst}};
    @(negedge wr_clk);
    for (int i = 0; i < NREQ; i++) if (acc[i]) widx[i]++;
    set_data();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int chs [6] = '{0, 1, 2, 3, 0, 1};
  int b, base;

  initial begin
    rst = 1'b1; rd_free = 1'b0; req_valid = '0; clr_data();
    @(negedge wr_clk);
    steps(2);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_din", fifo_din, 0);
    chk("rst_ch", fifo_ch, 0);
    chk("rst_start", burst_start, 0);
    chk("rst_end", burst_end, 0);
    chk("rst_pad", burst_padded, 0);
    chk("rst_cerr", credit_err, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_credits", dut.credits, 100);

    // All four valid, no rd_free: six bursts 0,1,2,3,0,1 then starved.
    rst = 1'b0; req_valid = '1;
    steps(107);
    chk("starve_credits", dut.credits, 4);
    chk("starve_ready", req_ready, 0);
    chk("rr_words", wq.size(), 96);
    for (int k = 0; k < 6; k++) begin
      b = 16*k;
      base = chs[k]*16 + ((k >= 4) ? 16 : 0);
      chk($sformatf("b%0d_ch", k), wq[b].ch, chs[k]);
      chk($sformatf("b%0d_start", k), wq[b].s, 1);
      chk($sformatf("b%0d_din0", k), wq[b].din, base);
      chk($sformatf("b%0d_end", k), wq[b+15].e, 1);
      chk($sformatf("b%0d_noend14", k), wq[b+14].e, 0);
      chk($sformatf("b%0d_dinL", k), wq[b+15].din, base + 15);
      chk($sformatf("b%0d_span", k), wq[b+15].cyc - wq[b].cyc, 15);
      chk($sformatf("b%0d_chL", k), wq[b+15].ch, chs[k]);
      if (k > 0) chk($sformatf("b%0d_gap", k), wq[b].cyc - wq[b-1].cyc, 2);
    end

    // 12 returns reach 16 credits; the grant cycle also carries a return.
    rd_free = 1'b1;
    steps(12);
    chk("refill_credits", dut.credits, 16);
    chk("refill_ready", req_ready, 0);
    step();
    chk("grant_rdfree_credits", dut.credits, 1);
    chk("grant_ch2_ready", req_ready, 4'b0100);
    wq.delete();

    // Channel 2 stalls after 5 words: 8 idle cycles then 11 pad words.
    steps(5);
    req_valid[2] = 1'b0;
    steps(8);
    chk("pad_ready", req_ready, 0);
    steps(2);
    rd_free = 1'b0;
    steps(9);
    chk("pad_idle_ready", req_ready, 0);
    chk("pad_credits", dut.credits, 16);
    step();
    chk("after_pad_ch3", req_ready, 4'b1000);
    chk("after_pad_credits", dut.credits, 0);
    chk("pad_words", wq.size(), 16);
    chk("pad_start", wq[0].s, 1);
    chk("pad_ch0", wq[0].ch, 2);
    chk("pad_din0", wq[0].din, 48);
    chk("pad_din4", wq[4].din, 52);
    chk("pad_din5", wq[5].din, 0);
    chk("pad_gap", wq[5].cyc - wq[4].cyc, 9);
    chk("pad_span", wq[15].cyc - wq[5].cyc, 10);
    chk("pad_end", wq[15].e, 1);
    chk("pad_padded", wq[15].p, 1);
    chk("pad_noend14", wq[14].e, 0);
    chk("pad_din15", wq[15].din, 0);
    chk("pad_chL", wq[15].ch, 2);
    wq.delete();

    // Reset after word 7 of channel 3's burst.
    steps(7);
    rst = 1'b1; req_valid = '0;
    step();
    chk("mid_rst_wr_en", fifo_wr_en, 0);
    chk("mid_rst_end", burst_end, 0);
    chk("mid_rst_ch", fifo_ch, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_credits", dut.credits, 100);
    chk("mid_rst_words", wq.size(), 7);
    chk("mid_rst_ch3", wq[0].ch, 3);
    chk("mid_rst_noend", wq[6].e, 0);
    rst = 1'b0; clr_data();

    // Return at full credits with no grant.
    rd_free = 1'b1;
    step();
    chk("cerr_set", credit_err, 1);
    chk("cerr_credits", dut.credits, 100);
    rd_free = 1'b0;
    steps(3);
    chk("cerr_sticky", credit_err, 1);
    req_valid = '1;
    step();
    chk("rst_prio_ch0", req_ready, 4'b0001);
    chk("rst_prio_credits", dut.credits, 84);
    rst = 1'b1; req_valid = '0;
    step();
    rst = 1'b0; clr_data();
    chk("cerr_cleared", credit_err, 0);
    wq.delete();

    // Only channel 1, then channel 0 joins mid-burst.
    req_valid = 4'b0010;
    step();
    chk("solo_ch1", req_ready, 4'b0010);
    steps(8);
    req_valid = 4'b0011;
    steps(4);
    chk("solo_mid", req_ready, 4'b0010);
    steps(4);
    chk("solo_idle", req_ready, 0);
    step();
    chk("next_ch0", req_ready, 4'b0001);
    chk("solo_words", wq.size(), 16);
    chk("solo_din0", wq[0].din, 16);
    chk("solo_dinL", wq[15].din, 31);
    chk("solo_chL", wq[15].ch, 1);
    chk("solo_end", wq[15].e, 1);
    steps(16);
    step();
    chk("back_ch1", req_ready, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
